// File: rtl/gtech_deser8.sv
// Serial-to-parallel deserializer with DV/DRDY handshake, sticky overrun and frame sync.
// Define GTECH_DESER8_PARITY_EN to add a 9th parity bit per word and the PERR output.
module gtech_deser8 #(
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned ODD_PAR   = 0
) (
  input  logic       CP,
  input  logic       CD,
  input  logic       SI,
  input  logic       SE,
  input  logic       SYNC,
  input  logic       DRDY,
  input  logic       CLR_OVF,
  output logic [7:0] DOUT,
  output logic       DV,
  output logic       BUSY,
  output logic       OVF
`ifdef GTECH_DESER8_PARITY_EN
  ,
  output logic       PERR
`endif
);

`ifdef GTECH_DESER8_PARITY_EN
  localparam logic [3:0] LAST_CNT = 4'd8;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  localparam logic [3:0] LAST_CNT = 4'd7;
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t     state;
  state_t     nxt_state;
  logic [7:0] sr;
  logic [7:0] base_sr;
  logic [7:0] shifted;
  logic [7:0] word;
  logic [3:0] cnt;
  logic [3:0] base_cnt;
  logic [3:0] nxt_cnt;
  logic       done;
  logic       accept;
`ifdef GTECH_DESER8_PARITY_EN
  logic       word_perr;
`else
  logic       unused_odd_par;
  assign unused_odd_par = (ODD_PAR != 0);
`endif

  // SYNC acts as if the counter and shift register were already cleared, so an
  // SE on the same edge lands as bit 0 of a fresh word.
  always_comb begin
    base_cnt  = SYNC ? '0 : cnt;
    base_sr   = SYNC ? '0 : sr;
    shifted   = (MSB_FIRST != 0) ? {base_sr[6:0], SI} : {SI, base_sr[7:1]};
    done      = SE && (base_cnt == LAST_CNT);
    accept    = !DV || DRDY;
    nxt_cnt   = base_cnt;
    if (SE) nxt_cnt = done ? '0 : base_cnt + 4'd1;
`ifdef GTECH_DESER8_PARITY_EN
    word      = base_sr;
    word_perr = ((^base_sr) ^ SI) != (ODD_PAR != 0);
`else
    word      = shifted;
`endif
    nxt_state = SHIFT;
    if (nxt_cnt == '0) nxt_state = IDLE;
`ifdef GTECH_DESER8_PARITY_EN
    else if (nxt_cnt == LAST_CNT) nxt_state = PAR;
`endif
  end

  assign BUSY = (state != IDLE);

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      DOUT  <= '0;
      DV    <= 1'b0;
      OVF   <= 1'b0;
`ifdef GTECH_DESER8_PARITY_EN
      PERR  <= 1'b0;
`endif
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (SE) sr <= done ? '0 : shifted;
      else    sr <= base_sr;

      if (done && accept) begin
        DOUT <= word;
        DV   <= 1'b1;
`ifdef GTECH_DESER8_PARITY_EN
        PERR <= word_perr;
`endif
      end else if (DV && DRDY) begin
        DV <= 1'b0;
      end

      // A fresh overrun wins over a simultaneous clear request.
      if (done && !accept) OVF <= 1'b1;
      else if (CLR_OVF)    OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gtech_deser8.sv
// Bench for gtech_deser8: directed scenarios plus random traffic against a bit-queue model.
// Honours GTECH_DESER8_PARITY_EN in the same way as the design.
module tb_gtech_deser8;

  localparam int unsigned MSB  = 0;
  localparam int unsigned ODDP = 0;
`ifdef GTECH_DESER8_PARITY_EN
  localparam int WBITS = 9;
`else
  localparam int WBITS = 8;
`endif

  logic       cp = 1'b0;
  logic       cd = 1'b1;
  logic       si, se, sync, drdy, clr_ovf;
  logic [7:0] dout;
  logic       dv, busy, ovf;
`ifdef GTECH_DESER8_PARITY_EN
  logic       perr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bit         q[$];
  logic [7:0] m_dout;
  logic       m_dv, m_ovf, m_perr;

  gtech_deser8 #(.MSB_FIRST(MSB), .ODD_PAR(ODDP)) dut (
    .CP(cp), .CD(cd), .SI(si), .SE(se), .SYNC(sync), .DRDY(drdy), .CLR_OVF(clr_ovf),
    .DOUT(dout), .DV(dv), .BUSY(busy), .OVF(ovf)
`ifdef GTECH_DESER8_PARITY_EN
    , .PERR(perr)
`endif
  );

  always #5 cp = ~cp;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic model_edge(input logic se_i, input logic si_i, input logic sync_i,
                            input logic drdy_i, input logic clr_i);
    logic [7:0] w;
    bit         p;
    bit         complete;
    bit         overrun;
    complete = 0;
    overrun  = 0;
    if (sync_i) q.delete();
    if (se_i) begin
      q.push_back(si_i);
      if (q.size() == WBITS) complete = 1;
    end
    if (complete) begin
      w = '0;
      p = 0;
      for (int i = 0; i < 8; i++) begin
        if (MSB != 0) w[7-i] = q[i];
        else          w[i]   = q[i];
        p ^= q[i];
      end
      if (WBITS == 9) p ^= q[8];
      q.delete();
      if (!m_dv || drdy_i) begin
        m_dout = w;
        m_dv   = 1'b1;
        m_perr = (p != (ODDP != 0));
      end else begin
        overrun = 1;
      end
    end else if (m_dv && drdy_i) begin
      m_dv = 1'b0;
    end
    if (overrun)    m_ovf = 1'b1;
    else if (clr_i) m_ovf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"}, dout, m_dout);
    chk({tag, ".dv"},   8'(dv),   8'(m_dv));
    chk({tag, ".busy"}, 8'(busy), 8'(q.size() != 0));
    chk({tag, ".ovf"},  8'(ovf),  8'(m_ovf));
`ifdef GTECH_DESER8_PARITY_EN
    chk({tag, ".perr"}, 8'(perr), 8'(m_perr));
`endif
  endtask

  task automatic cycle(input string tag, input logic se_i, input logic si_i, input logic sync_i,
                       input logic drdy_i, input logic clr_i);
    se = se_i; si = si_i; sync = sync_i; drdy = drdy_i; clr_ovf = clr_i;
    model_edge(se_i, si_i, sync_i, drdy_i, clr_i);
    @(posedge cp);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input string tag, input logic [7:0] data, input logic par,
                           input logic drdy_mid, input logic drdy_last);
    logic b;
    for (int i = 0; i < WBITS; i++) begin
      if (i < 8) b = data[(MSB != 0) ? 7 - i : i];
      else       b = par;
      cycle(tag, 1'b1, b, 1'b0, (i == WBITS - 1) ? drdy_last : drdy_mid, 1'b0);
    end
  endtask

  initial begin
    cd = 1'b0; si = 1'b0; se = 1'b0; sync = 1'b0; drdy = 1'b0; clr_ovf = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge cp);
    cd = 1'b1;

    // Basic word, then DV drops on the next DRDY edge.
    send_word("w85", 8'h85, 1'b1, 1'b1, 1'b1);
    chk("w85_dout", dout, 8'h85);
    chk("w85_dv", 8'(dv), 8'd1);
    cycle("w85_ack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("w85_dv_clr", 8'(dv), 8'd0);

    // Overrun: second word discarded, then cleared.
    send_word("ovA", 8'h5A, 1'b0, 1'b0, 1'b0);
    send_word("ovB", 8'hC3, 1'b0, 1'b0, 1'b0);
    chk("ov_held", dout, 8'h5A);
    chk("ov_flag", 8'(ovf), 8'd1);
    cycle("ov_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ov_cleared", 8'(ovf), 8'd0);

    // Reload on the same edge DV is acknowledged.
    send_word("r3c", 8'h3C, 1'b0, 1'b0, 1'b1);
    chk("r3c_dout", dout, 8'h3C);
    chk("r3c_dv", 8'(dv), 8'd1);
    chk("r3c_ovf", 8'(ovf), 8'd0);
    cycle("r3c_ack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // SYNC with SE mid-word restarts at bit 0.
    cycle("sy0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle("sy1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle("sy2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("sy3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle("sync", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("sync_busy", 8'(busy), 8'd1);
    for (int i = 0; i < WBITS - 1; i++) cycle("sy_tail", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sync_dout", dout, 8'h01);

    // Asynchronous clear mid-word with a held word.
    send_word("wA5", 8'hA5, 1'b0, 1'b1, 1'b1);
    chk("wA5_dout", dout, 8'hA5);
    for (int i = 0; i < 5; i++) cycle("cd_part", 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    #2;
    cd = 1'b0;
    model_reset();
    #1;
    check_all("cd_async");
    chk("cd_dout", dout, 8'h00);
    chk("cd_busy", 8'(busy), 8'd0);
    #2;
    cd = 1'b1;
    send_word("w96", 8'h96, 1'b0, 1'b1, 1'b1);
    chk("w96_dout", dout, 8'h96);

`ifdef GTECH_DESER8_PARITY_EN
    send_word("p07a", 8'h07, 1'b0, 1'b1, 1'b1);
    chk("p07_bad", 8'(perr), 8'd1);
    send_word("p07b", 8'h07, 1'b1, 1'b1, 1'b1);
    chk("p07_good", 8'(perr), 8'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      cycle("rand", $urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gtech_deser8.md
GTECH_DESER8 -- requirements
Module: gtech_deser8

Interface
REQ-001 Parameter MSB_FIRST, default 0; 0 = first received bit lands in DOUT[0], 1 = first received bit lands in DOUT[7].
REQ-002 Parameter ODD_PAR, default 0; parity sense when GTECH_DESER8_PARITY_EN is defined; 0 = even, 1 = odd; ignored otherwise.
REQ-003 CP  input  1  clock; all state changes on rising edge.
REQ-004 CD  input  1  asynchronous active-low clear.
REQ-005 SI  input  1  serial data bit.
REQ-006 SE  input  1  shift enable; SI is sampled on CP rising edge when SE=1.
REQ-007 SYNC  input  1  frame align; synchronously discards any partial word.
REQ-008 DRDY  input  1  downstream register ready to load.
REQ-009 CLR_OVF  input  1  synchronous clear of OVF.
REQ-010 DOUT  output  8  assembled word, feeds the 8-bit register D0..D7 inputs.
REQ-011 DV  output  1  DOUT valid.
REQ-012 BUSY  output  1  partial word in progress (bit count nonzero).
REQ-013 OVF  output  1  sticky overrun flag.
REQ-014 PERR  output  1  parity error for the word on DOUT; present only with GTECH_DESER8_PARITY_EN.

Function
REQ-015 The block SHALL hold a shift register, a 4-bit bit counter (CNT), a holding register driving DOUT, and the DV, OVF and PERR flags; all outputs SHALL be registered.
REQ-016 The FSM SHALL have states IDLE (CNT=0), SHIFT (1<=CNT<=7) and, with parity, PAR (CNT=8); BUSY SHALL equal (state != IDLE).
REQ-017 Each edge with SE=1 SHALL sample SI into the shift register and increment CNT; SE=0 SHALL hold all shift state.
REQ-018 On the edge sampling the final bit (8th, or 9th with parity), CNT SHALL return to 0 and the word SHALL load into DOUT with DV=1 from that edge; latency is 0 cycles after the final sampling edge.
REQ-019 DV SHALL clear on an edge where DV=1 and DRDY=1, unless a new word completes on the same edge; in that case DOUT SHALL take the new word and DV SHALL stay 1.
REQ-020 A word completing while DV=1 and DRDY=0 SHALL be discarded; DOUT and DV SHALL hold; OVF SHALL set.
REQ-021 OVF SHALL clear on an edge with CLR_OVF=1; a simultaneous overrun SHALL take priority, leaving OVF=1.
REQ-022 SYNC=1 SHALL force CNT to 0 and discard the partial word; if SE=1 on the same edge, SI SHALL be taken as bit 0 and CNT SHALL become 1.
REQ-023 SYNC SHALL NOT affect DOUT, DV, OVF or PERR.
REQ-024 DOUT SHALL be stable whenever DV=1 except at a REQ-019 reload edge.

Reset
REQ-025 CD=0 SHALL immediately set DOUT=8'h00, DV=0, BUSY=0, OVF=0, PERR=0, CNT=0, shift register=0, state=IDLE, independent of CP.
REQ-026 CD asserted mid-word SHALL discard the partial word; after CD deassertion, the first SE=1 edge SHALL be bit 0.

Configuration
REQ-027 Macro GTECH_DESER8_PARITY_EN defined: a 9th SE bit SHALL be the parity bit; PERR SHALL load with DOUT and SHALL be 1 when the parity of the 9 bits mismatches ODD_PAR; PERR SHALL update only when DOUT loads.
REQ-028 Macro GTECH_DESER8_PARITY_EN undefined: words SHALL be 8 bits, state PAR and port PERR SHALL be absent, and CNT wraps after 8.

Verification
REQ-029 MSB_FIRST=0, SE=1, bits 1,0,1,0,0,0,0,1, DRDY=1 -> DOUT=8'h85 with DV=1 after the 8th edge, then DV=0 on the next edge.
REQ-030 Two back-to-back words with DRDY=0 -> first word held, OVF=1; assert CLR_OVF -> OVF=0 on the next edge.
REQ-031 4 bits shifted, then SYNC=1 with SE=1 and SI=1, then 7 more bits of 0 -> DOUT=8'h01 (MSB_FIRST=0), BUSY=1 throughout.
REQ-032 CD pulsed low after 5 bits, with DV=1 holding 8'hA5 -> DOUT=0, DV=0, BUSY=0 asynchronously; the next 8 bits form a clean word.
REQ-033 DV=1 and DRDY=1 on the same edge a new word 8'h3C completes -> DV stays 1, DOUT=8'h3C, OVF=0.
REQ-034 Parity enabled, ODD_PAR=0, data 8'h07 with parity bit 0 -> PERR=1; data 8'h07 with parity bit 1 -> PERR=0.
